// File: rtl/pause_dim_if.sv
// Pixel stream bundle: pixel enable, syncs, blanks and packed RGB332.
// master drives the stream, slave consumes it.
interface pause_dim_if;
  logic       ce;
  logic       hs;
  logic       vs;
  logic       hblank;
  logic       vblank;
  logic [7:0] rgb;

  modport master (
    output ce, hs, vs, hblank, vblank, rgb
  );

  modport slave (
    input ce, hs, vs, hblank, vblank, rgb
  );
endinterface

// File: rtl/pause_dim.sv
// Pause toggle with OSD-forced pause and screen dimming after a long pause.
// Define PAUSE_DIM_EN to build the dim counter and DIMMED state.
module pause_dim #(
  parameter logic [31:0] DIM_CYCLES = 32'd240000000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pause_btn,
  input  logic osd_status,
  input  logic osd_pause_en,
  pause_dim_if.slave  src,
  pause_dim_if.master dst,
  output logic pause,
  output logic dimmed
);

  if (DIM_CYCLES == 32'd0) begin : g_bad_dim
    $error("DIM_CYCLES must be at least 1");
  end

  logic btn_q;
  logic armed;
  logic user_pause;
  logic btn_rise;
  logic user_nxt;
  logic pause_req;
  logic dim_sel;

  // armed masks the first post-reset cycle so a held button cannot toggle
  assign btn_rise  = armed & pause_btn & ~btn_q;
  assign user_nxt  = user_pause ^ btn_rise;
  assign pause_req = user_nxt | (osd_pause_en & osd_status);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      btn_q      <= 1'b0;
      armed      <= 1'b0;
      user_pause <= 1'b0;
      pause      <= 1'b0;
    end else begin
      btn_q      <= pause_btn;
      armed      <= 1'b1;
      user_pause <= user_nxt;
      pause      <= pause_req;
    end
  end

`ifdef PAUSE_DIM_EN
  typedef enum logic [1:0] {
    RUN,
    PAUSED,
    DIMMED
  } state_t;

  localparam logic [31:0] LAST = DIM_CYCLES - 32'd1;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] cnt;
  logic [31:0] cnt_nxt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN: begin
        if (pause_req) begin
          state_nxt = PAUSED;
          cnt_nxt   = '0;
        end
      end
      PAUSED: begin
        if (!pause_req) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = DIMMED;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      DIMMED: begin
        if (!pause_req) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign dimmed  = (state == DIMMED);
  // pixel dims on the same edge the dimmed flag rises
  assign dim_sel = (state_nxt == DIMMED);
`else
  assign dimmed  = 1'b0;
  assign dim_sel = 1'b0;
`endif

  function automatic logic [7:0] halve(input logic [7:0] p);
    return {1'b0, p[7:6], 1'b0, p[4:3], 1'b0, p[1]};
  endfunction

  logic       ce_q;
  logic       hs_q;
  logic       vs_q;
  logic       hb_q;
  logic       vb_q;
  logic [7:0] rgb_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ce_q  <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      hb_q  <= 1'b0;
      vb_q  <= 1'b0;
      rgb_q <= 8'h00;
    end else begin
      ce_q  <= src.ce;
      hs_q  <= src.hs;
      vs_q  <= src.vs;
      hb_q  <= src.hblank;
      vb_q  <= src.vblank;
      rgb_q <= dim_sel ? halve(src.rgb) : src.rgb;
    end
  end

  assign dst.ce     = ce_q;
  assign dst.hs     = hs_q;
  assign dst.vs     = vs_q;
  assign dst.hblank = hb_q;
  assign dst.vblank = vb_q;
  assign dst.rgb    = rgb_q;

endmodule
